gray_cnt_sched: RTL

//   Run-controller for a Gray-coded counter. Sequences start/pause/stop of an internal

---
 rtl/gray_cnt_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/gray_cnt_sched.sv
// ============================================================================
// Module   : gray_cnt_sched
// Purpose  : Run controller for a Gray-coded counter with start/pause/stop,
//            valid/ready terminal-count config, one-shot done or reload wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_cnt_sched #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            cfg_valid_i,
  output logic            cfg_ready_o,
  input  logic [SIZE-1:0] cfg_limit_i,
  input  logic            cfg_reload_i,
  input  logic            start_i,
  input  logic            pause_i,
  input  logic            stop_i,
  input  logic            inc_en_i,
  output logic [SIZE-1:0] q_o,
  output logic [SIZE-1:0] q_bin_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            wrap_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [SIZE-1:0] C_ONE = {{(SIZE-1){1'b0}}, 1'b1};

  state_t          state_q;
  logic [SIZE-1:0] bin_q;
  logic [SIZE-1:0] gray_q;
  logic [SIZE-1:0] limit_q;
  logic            reload_q;
  logic            busy_q;
  logic            done_q;
  logic            wrap_q;

  logic [SIZE-1:0] w_bin_inc;
  logic [SIZE-1:0] w_gray_inc;
  logic            w_at_limit;
  logic            w_cfg_accept;

  // Gray code is derived from the next binary value so q and q_bin update together.
  always_comb begin
    w_bin_inc    = bin_q + C_ONE;
    w_gray_inc   = w_bin_inc ^ (w_bin_inc >> 1);
    w_at_limit   = (bin_q == limit_q);
    cfg_ready_o  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    w_cfg_accept = cfg_valid_i & cfg_ready_o;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      gray_q   <= '0;
      limit_q  <= '1;
      reload_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (w_cfg_accept) begin
        limit_q  <= cfg_limit_i;
        reload_q <= cfg_reload_i;
      end
      if (stop_i) begin
        state_q <= ST_IDLE;
        bin_q   <= '0;
        gray_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start_i) begin
              state_q <= ST_RUN;
              bin_q   <= '0;
              gray_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (pause_i) begin
              state_q <= ST_HOLD;
            end else if (inc_en_i) begin
              if (!w_at_limit) begin
                bin_q  <= w_bin_inc;
                gray_q <= w_gray_inc;
              end else if (reload_q) begin
                bin_q  <= '0;
                gray_q <= '0;
                wrap_q <= 1'b1;
              end else begin
                // One-shot: count stays parked at the limit.
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (!pause_i) state_q <= ST_RUN;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign q_o     = gray_q;
  assign q_bin_o = bin_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign wrap_o  = wrap_q;

endmodule

`default_nettype wire
